detect_sequence_param_fsm: RTL and testbench

Parametrised, runtime-programmable serial sequence detector. It is the successor to the fixed-pattern FSM detectors in the finite_state_machines section. Pattern and length (1..MAX_LEN) are loaded at run time, with overlap or non-overlap matching and a saturating match counter. It sits on a one-bit serial stream qualified by in_valid.

---
 rtl/detect_sequence_param_fsm.sv | 111 +++++++++++
 tb/tb_detect_sequence_param_fsm.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/detect_sequence_param_fsm.sv
// Runtime-programmable serial sequence detector with overlap control and a saturating match counter.
// Optional macro DETECT_SEQ_PARAM_CNT_CLR_EN adds a synchronous cnt_clr input for match_count.
module detect_sequence_param_fsm #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
`ifdef DETECT_SEQ_PARAM_CNT_CLR_EN
    input  logic               cnt_clr,
`endif
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               a,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               armed
);
    // Stream handshake: a is consumed on every posedge where in_valid is high and
    // cfg_load is low; there is no backpressure, so every valid bit is taken.

    typedef enum logic [1:0] {UNCFG, FILL, RUN} state_t;

    state_t             state;
    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   fill;
    logic               ovl;

    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_next;
    logic               cfg_legal;
    logic               take_bit;
    logic               match;
    logic [CNT_W-1:0]   count_base;
    logic [CNT_W-1:0]   count_next;

    always_comb begin
        cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        take_bit  = in_valid && !cfg_load && (state != UNCFG);
        hist_next = {hist[MAX_LEN-2:0], a};
        fill_next = (fill < len) ? fill + LEN_W'(1) : len;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        // fill gates matching, so stale history bits never contribute to a match
        match = take_bit && (fill_next >= len) && ((hist_next & mask) == (pat & mask));
    end

    always_comb begin
`ifdef DETECT_SEQ_PARAM_CNT_CLR_EN
        count_base = cnt_clr ? '0 : match_count;
`else
        count_base = match_count;
`endif
        count_next = count_base;
        if (match && (count_base != {CNT_W{1'b1}})) begin
            count_next = count_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= UNCFG;
            hist        <= '0;
            fill        <= '0;
            pat         <= '0;
            len         <= '0;
            ovl         <= 1'b0;
            detected    <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
            armed       <= 1'b0;
        end else begin
            detected    <= 1'b0;
            cfg_err     <= 1'b0;
            match_count <= count_next;
            if (cfg_load) begin
                if (cfg_legal) begin
                    pat   <= cfg_pattern;
                    len   <= cfg_len;
                    ovl   <= cfg_overlap;
                    hist  <= '0;
                    fill  <= '0;
                    state <= FILL;
                    armed <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else if (take_bit) begin
                hist     <= hist_next;
                detected <= match;
                if (match && !ovl) begin
                    fill  <= '0;
                    state <= FILL;
                end else begin
                    fill  <= fill_next;
                    state <= (fill_next == len) ? RUN : FILL;
                end
            end
        end
    end

endmodule

// File: tb/tb_detect_sequence_param_fsm.sv
// Randomized and directed bench for detect_sequence_param_fsm against a queue-based reference model.
module tb_detect_sequence_param_fsm;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               in_valid = 1'b0;
  logic               a = 1'b0;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic               armed;
`ifdef DETECT_SEQ_PARAM_CNT_CLR_EN
  logic               cnt_clr = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // reference model: bits received since the last clear, newest at the back
  bit                 hist_q[$];
  logic               m_armed;
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  logic               exp_det;
  logic               exp_err;
  logic [CNT_W-1:0]   exp_cnt;

  detect_sequence_param_fsm #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
`ifdef DETECT_SEQ_PARAM_CNT_CLR_EN
    .cnt_clr(cnt_clr),
`endif
    .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
    .in_valid(in_valid),
    .a(a),
    .detected(detected),
    .match_count(match_count),
    .cfg_err(cfg_err),
    .armed(armed)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    hist_q.delete();
    m_armed = 1'b0;
    m_pat   = '0;
    m_len   = 0;
    m_ovl   = 1'b0;
    exp_det = 1'b0;
    exp_err = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic model_apply(input bit ld, input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                             input bit o, input bit v, input bit b);
    bit hit;
    exp_det = 1'b0;
    exp_err = 1'b0;
    if (ld) begin
      if (int'(l) >= 1 && int'(l) <= MAX_LEN) begin
        m_pat   = p;
        m_len   = int'(l);
        m_ovl   = o;
        m_armed = 1'b1;
        hist_q.delete();
      end else begin
        exp_err = 1'b1;
      end
    end else if (v && m_armed) begin
      hist_q.push_back(b);
      if (hist_q.size() > MAX_LEN) void'(hist_q.pop_front());
      if (hist_q.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++) begin
          if (hist_q[hist_q.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
        end
        if (hit) begin
          exp_det = 1'b1;
          if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
          if (!m_ovl) hist_q.delete();
        end
      end
    end
  endtask

  task automatic step(input bit ld, input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                      input bit o, input bit v, input bit b);
    @(negedge clk);
    cfg_load = ld; cfg_pattern = p; cfg_len = l; cfg_overlap = o; in_valid = v; a = b;
    model_apply(ld, p, l, o, v, b);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    cfg_load = 1'b0; in_valid = 1'b0; a = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++; if (detected !== 1'b0) begin errors++; $display("FAIL reset_detected: got %b want 0", detected); end
    checks++; if (match_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", match_count); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %b want 0", armed); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      checks++;
      if ({detected, cfg_err, armed, match_count} !== {exp_det, exp_err, m_armed, exp_cnt}) begin
        errors++; $display("FAIL unconfigured step %0d: det/err/armed/cnt=%h want %h", i,
                           {detected, cfg_err, armed, match_count}, {exp_det, exp_err, m_armed, exp_cnt});
      end
    end
  endtask

  task automatic test_stream_110011(input bit ovl, input int want_cnt);
    logic [9:0] bits;
    bits = 10'b1100110011;
    do_reset();
    step(1'b1, 8'b00110011, 4'd6, ovl, 1'b0, 1'b0);
    for (int i = 9; i >= 0; i--) begin
      step(1'b0, cfg_pattern, cfg_len, cfg_overlap, 1'b1, bits[i]);
      checks++;
      if ({detected, cfg_err, armed, match_count} !== {exp_det, exp_err, m_armed, exp_cnt}) begin
        errors++; $display("FAIL stream_ovl%0b bit %0d: det/err/armed/cnt=%h want %h", ovl, 10 - i,
                           {detected, cfg_err, armed, match_count}, {exp_det, exp_err, m_armed, exp_cnt});
      end
    end
    checks++;
    if (match_count !== CNT_W'(want_cnt)) begin
      errors++; $display("FAIL stream_ovl%0b_total: got %0d want %0d", ovl, match_count, want_cnt);
    end
  endtask

  task automatic test_valid_gap();
    logic [9:0] v;
    logic [9:0] d;
    v = 10'b1100011111;
    d = 10'b1000010101;
    do_reset();
    step(1'b1, 8'b00001010, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 9; i >= 0; i--) begin
      step(1'b0, cfg_pattern, cfg_len, cfg_overlap, v[i], v[i] ? d[i] : 1'($urandom_range(0, 1)));
      checks++;
      if ({detected, cfg_err, armed, match_count} !== {exp_det, exp_err, m_armed, exp_cnt}) begin
        errors++; $display("FAIL valid_gap cycle %0d: det/err/armed/cnt=%h want %h", 10 - i,
                           {detected, cfg_err, armed, match_count}, {exp_det, exp_err, m_armed, exp_cnt});
      end
    end
    checks++;
    if (match_count !== 8'd2) begin errors++; $display("FAIL valid_gap_total: got %0d want 2", match_count); end
  endtask

  task automatic test_illegal_cfg();
    logic [3:0] bits;
    int err_seen;
    bits = 4'b1010;
    err_seen = 0;
    do_reset();
    step(1'b1, 8'b00001010, 4'd4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'b11111111, 4'd0, 1'b0, 1'b0, 1'b0);
    err_seen += int'(cfg_err);
    step(1'b1, 8'b11111111, 4'(MAX_LEN + 1), 1'b0, 1'b0, 1'b0);
    err_seen += int'(cfg_err);
    checks++;
    if (err_seen != 2 || armed !== 1'b1) begin
      errors++; $display("FAIL illegal_cfg_pulses: got %0d pulses armed=%b want 2 pulses armed=1", err_seen, armed);
    end
    for (int i = 3; i >= 0; i--) begin
      step(1'b0, 8'b11111111, 4'd0, 1'b0, 1'b1, bits[i]);
      checks++;
      if ({detected, cfg_err, armed, match_count} !== {exp_det, exp_err, m_armed, exp_cnt}) begin
        errors++; $display("FAIL illegal_cfg bit %0d: det/err/armed/cnt=%h want %h", 4 - i,
                           {detected, cfg_err, armed, match_count}, {exp_det, exp_err, m_armed, exp_cnt});
      end
    end
    checks++;
    if (match_count !== 8'd1) begin errors++; $display("FAIL illegal_cfg_total: got %0d want 1", match_count); end
  endtask

  task automatic test_reload_midstream();
    logic [11:0] bits;
    bits = 12'b110011110011;
    do_reset();
    step(1'b1, 8'b00110011, 4'd6, 1'b1, 1'b0, 1'b0);
    for (int i = 11; i >= 0; i--) begin
      if (i == 8) step(1'b1, 8'b00110011, 4'd6, 1'b1, 1'b0, 1'b0);
      step(1'b0, cfg_pattern, cfg_len, cfg_overlap, 1'b1, bits[i]);
      checks++;
      if ({detected, cfg_err, armed, match_count} !== {exp_det, exp_err, m_armed, exp_cnt}) begin
        errors++; $display("FAIL reload bit %0d: det/err/armed/cnt=%h want %h", 12 - i,
                           {detected, cfg_err, armed, match_count}, {exp_det, exp_err, m_armed, exp_cnt});
      end
    end
    checks++;
    if (match_count !== 8'd1) begin errors++; $display("FAIL reload_total: got %0d want 1", match_count); end
  endtask

  task automatic test_async_reset();
    logic [3:0] bits;
    bits = 4'b1010;
    do_reset();
    step(1'b1, 8'b00001010, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) step(1'b0, cfg_pattern, cfg_len, cfg_overlap, 1'b1, bits[i]);
    checks++;
    if (detected !== 1'b1 || match_count !== 8'd1) begin
      errors++; $display("FAIL async_pre: det=%b cnt=%0d want det=1 cnt=1", detected, match_count);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({detected, armed, match_count} !== 10'd0) begin
      errors++; $display("FAIL async_reset: det=%b armed=%b cnt=%0d want all 0", detected, armed, match_count);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    step(1'b1, 8'b00000001, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) begin
      step(1'b0, cfg_pattern, cfg_len, cfg_overlap, 1'b1, 1'b1);
      checks++;
      if ({detected, cfg_err, armed, match_count} !== {exp_det, exp_err, m_armed, exp_cnt}) begin
        errors++; $display("FAIL saturation step %0d: det/err/armed/cnt=%h want %h", i,
                           {detected, cfg_err, armed, match_count}, {exp_det, exp_err, m_armed, exp_cnt});
      end
    end
    checks++;
    if (match_count !== 8'd255) begin errors++; $display("FAIL saturation_total: got %0d want 255", match_count); end
  endtask

  task automatic test_len1_nonoverlap();
    do_reset();
    step(1'b1, 8'b00000001, 4'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      step(1'b0, cfg_pattern, cfg_len, cfg_overlap, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      checks++;
      if ({detected, cfg_err, armed, match_count} !== {exp_det, exp_err, m_armed, exp_cnt}) begin
        errors++; $display("FAIL len1 step %0d: det/err/armed/cnt=%h want %h", i,
                           {detected, cfg_err, armed, match_count}, {exp_det, exp_err, m_armed, exp_cnt});
      end
    end
  endtask

  task automatic test_back_to_back_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0)
        step(1'b1, MAX_LEN'($urandom), LEN_W'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        step(1'b0, cfg_pattern, cfg_len, cfg_overlap, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      checks++;
      if ({detected, cfg_err, armed, match_count} !== {exp_det, exp_err, m_armed, exp_cnt}) begin
        errors++; $display("FAIL random step %0d: det/err/armed/cnt=%h want %h", i,
                           {detected, cfg_err, armed, match_count}, {exp_det, exp_err, m_armed, exp_cnt});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream_110011(1'b1, 2);
    test_stream_110011(1'b0, 1);
    test_valid_gap();
    test_illegal_cfg();
    test_reload_midstream();
    test_async_reset();
    test_len1_nonoverlap();
    test_saturation();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
